// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path: FSM state encoding,
// mouse command bytes, default timing and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_ACK       = 3'd6,
    ST_WAIT_IDLE = 3'd7
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  localparam int PS2_INHIBIT_CYCLES = 6000;
  localparam int PS2_TIMEOUT_CYCLES = 1000000;
  localparam int PS2_SYNC_STAGES    = 2;

  // Odd parity: the nine transmitted bits always carry an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Metastability synchronizer for one raw PS/2 pin plus a falling-edge detector
// built from one extra history flop behind the synchronized level.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Shift the pin through the synchronizer; reset to the idle-high bus level so no edge appears out of reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_r <= '1;
      hist_r <= 1'b1;
    end else begin
      sync_r <= (sync_r << 1) | SYNC_STAGES'(line_in);
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign fall  = hist_r & ~sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 8 data bits,
// odd parity, stop, ack). Define PS2_TX_RETRY_EN to allow one automatic retry.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = PS2_SYNC_STAGES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  ps2_tx_state_t    state_r;
  logic [8:0]       frame_r;
  logic [3:0]       fe_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             req_hold_r;
  logic             ack_r;
  logic             clk_oe_r;
  logic             dat_oe_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             cmd_ready_r;
`ifdef PS2_TX_RETRY_EN
  logic             retry_used_r;
`endif

  logic clk_lvl_s;
  logic clk_fe_s;
  logic dat_lvl_s;
  logic dat_fall_unused_s;
  logic tmo_active_s;
  logic finish_s;
  logic tmo_exp_s;
  logic fail_s;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_clk_in),
    .level    (clk_lvl_s),
    .fall     (clk_fe_s)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .line_in  (ps2_dat_in),
    .level    (dat_lvl_s),
    .fall     (dat_fall_unused_s)
  );

  // A device falling edge always beats an expiring timeout in the same cycle.
  assign tmo_active_s = (state_r != ST_IDLE) && (state_r != ST_INHIBIT);
  assign finish_s     = (state_r == ST_WAIT_IDLE) && clk_lvl_s && dat_lvl_s;
  assign tmo_exp_s    = tmo_active_s && !clk_fe_s && !finish_s && (tmo_cnt_r == '0);
  assign fail_s       = tmo_exp_s || (finish_s && !ack_r);

  // Transmit sequencer: owns both line drivers, handshake and status pulses.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      frame_r      <= 9'd0;
      fe_cnt_r     <= 4'd0;
      inh_cnt_r    <= '0;
      tmo_cnt_r    <= '0;
      req_hold_r   <= 1'b0;
      ack_r        <= 1'b0;
      clk_oe_r     <= 1'b0;
      dat_oe_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cmd_ready_r  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_used_r <= 1'b0;
`endif
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;

      if (tmo_active_s) begin
        if (clk_fe_s) begin
          tmo_cnt_r <= TMO_LOAD;
        end else if (tmo_cnt_r != '0) begin
          tmo_cnt_r <= tmo_cnt_r - TMO_ONE;
        end
      end

      if (fail_s) begin
`ifdef PS2_TX_RETRY_EN
        if (!retry_used_r) begin
          retry_used_r <= 1'b1;
          state_r      <= ST_INHIBIT;
          inh_cnt_r    <= INH_LOAD;
          fe_cnt_r     <= 4'd0;
          clk_oe_r     <= 1'b1;
          dat_oe_r     <= 1'b0;
        end else begin
          state_r  <= ST_IDLE;
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          busy_r   <= 1'b0;
          error_r  <= 1'b1;
        end
`else
        state_r  <= ST_IDLE;
        clk_oe_r <= 1'b0;
        dat_oe_r <= 1'b0;
        busy_r   <= 1'b0;
        error_r  <= 1'b1;
`endif
      end else if (finish_s) begin
        state_r  <= ST_IDLE;
        clk_oe_r <= 1'b0;
        dat_oe_r <= 1'b0;
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cmd_ready_r <= 1'b1;
            if (cmd_valid && cmd_ready_r) begin
              frame_r      <= {ps2_odd_parity(cmd_data), cmd_data};
              inh_cnt_r    <= INH_LOAD;
              fe_cnt_r     <= 4'd0;
              clk_oe_r     <= 1'b1;
              dat_oe_r     <= 1'b0;
              busy_r       <= 1'b1;
              cmd_ready_r  <= 1'b0;
              state_r      <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_used_r <= 1'b0;
`endif
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt_r == '0) begin
              dat_oe_r   <= 1'b1;
              req_hold_r <= 1'b1;
              tmo_cnt_r  <= TMO_LOAD;
              state_r    <= ST_REQ;
            end else begin
              inh_cnt_r <= inh_cnt_r - INH_ONE;
            end
          end
          ST_REQ: begin
            // Start bit goes out with the clock still held, then the clock is released.
            if (req_hold_r) begin
              clk_oe_r   <= 1'b0;
              req_hold_r <= 1'b0;
            end else if (clk_fe_s) begin
              dat_oe_r <= ~frame_r[0];
              fe_cnt_r <= 4'd1;
              state_r  <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (clk_fe_s) begin
              dat_oe_r <= ~frame_r[fe_cnt_r];
              fe_cnt_r <= fe_cnt_r + 4'd1;
              if (fe_cnt_r == 4'd7) begin
                state_r <= ST_PARITY;
              end
            end
          end
          ST_PARITY: begin
            if (clk_fe_s) begin
              dat_oe_r <= ~frame_r[8];
              fe_cnt_r <= fe_cnt_r + 4'd1;
              state_r  <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (clk_fe_s) begin
              dat_oe_r <= 1'b0;
              fe_cnt_r <= fe_cnt_r + 4'd1;
              state_r  <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (clk_fe_s) begin
              ack_r    <= ~dat_lvl_s;
              fe_cnt_r <= fe_cnt_r + 4'd1;
              state_r  <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            state_r <= ST_WAIT_IDLE;
          end
          default: begin
            state_r  <= ST_IDLE;
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: bus-functional PS/2 mouse model on open-drain
// lines plus a frame-level reference model (start, LSB-first data, odd parity, stop).
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 300;
  localparam int TMO  = 500;
  localparam int HALF = 40;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int rdy_bad_cnt = 0;

  assign clk_line = ps2_clk_oe ? 1'b0 : dev_clk;
  assign dat_line = ps2_dat_oe ? 1'b0 : dev_dat;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1800000;
    $display("FAIL global_watchdog: simulation did not end, observed running expected finished");
    $fatal(1);
  end

  always @(negedge CLOCK_50) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
    if (busy && cmd_ready) rdy_bad_cnt <= rdy_bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device should see it: {stop, parity, data, start}.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  task automatic device_receive(input logic ack_bit, input int abort_fe, input logic inject,
                                output logic [10:0] frame, output int low_cycles, output logic ok);
    int n;
    ok = 1'b1;
    frame = '0;
    low_cycles = 0;
    n = 0;
    while (!ps2_clk_oe && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!ps2_clk_oe) begin
      ok = 1'b0;
      return;
    end
    while (ps2_clk_oe && low_cycles < 5000) begin
      if (inject && low_cycles == 10) begin
        check("ready_low_while_busy", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h00;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge CLOCK_50);
      low_cycles++;
    end
    cmd_valid = 1'b0;
    if (ps2_clk_oe) begin
      ok = 1'b0;
      return;
    end
    repeat (20) @(negedge CLOCK_50);
    frame[0] = dat_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == abort_fe) begin
        repeat (4) @(negedge CLOCK_50);
        return;
      end
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = dat_line;
      if (k == 10) begin
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_dat = ack_bit;
        repeat (HALF / 2) @(negedge CLOCK_50);
      end else if (k == 11) begin
        dev_dat = 1'b1;
      end else begin
        repeat (HALF) @(negedge CLOCK_50);
      end
    end
  endtask

  task automatic wait_result(output logic gd, output logic ge, output logic to);
    gd = 1'b0;
    ge = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_50);
      if (done || error) begin
        gd = done;
        ge = error;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [7:0] b, input logic ack_bit, input logic inject, input string tag);
    logic [10:0] fr;
    int low, d0, e0;
    logic ok, gd, ge, to;
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(b);
    check({tag, "_busy"}, busy, 1'b1);
    device_receive(ack_bit, 0, inject, fr, low, ok);
    check({tag, "_bfm_ok"}, ok, 1'b1);
    check({tag, "_inhibit_len"}, (low >= INH), 1'b1);
    check({tag, "_frame"}, fr, exp_frame(b));
`ifdef PS2_TX_RETRY_EN
    if (ack_bit) begin
      device_receive(ack_bit, 0, 1'b0, fr, low, ok);
      check({tag, "_retry_ok"}, ok, 1'b1);
      check({tag, "_retry_frame"}, fr, exp_frame(b));
    end
`endif
    wait_result(gd, ge, to);
    check({tag, "_result_timeout"}, to, 1'b0);
    check({tag, "_done"}, gd, !ack_bit);
    check({tag, "_error"}, ge, ack_bit);
    check({tag, "_post_lines"}, {busy, ps2_clk_oe, ps2_dat_oe, cmd_ready}, 4'b0000);
    @(negedge CLOCK_50);
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_done_count"}, done_cnt - d0, (ack_bit ? 0 : 1));
    check({tag, "_error_count"}, err_cnt - e0, (ack_bit ? 1 : 0));
  endtask

  initial begin
    int t_start, t_cyc, d0, e0, low;
    logic prev_dat, ok;
    logic [10:0] fr;
    logic [7:0] rb;
    logic ra;

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, done, error}, 6'b100000);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("idle_outputs", {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

    run_txn(PS2_CMD_ENABLE, 1'b0, 1'b0, "f4");
    run_txn(PS2_CMD_RESET, 1'b0, 1'b0, "ff");
    run_txn(8'hED, 1'b1, 1'b0, "ed_nack");

    // Device never clocks: error must follow REQ entry by TIMEOUT_CYCLES.
    d0 = done_cnt;
    send_cmd(8'hA5);
    t_start = -1;
    t_cyc = 0;
    prev_dat = ps2_dat_oe;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLOCK_50);
      t_cyc++;
      if (ps2_dat_oe && !prev_dat) t_start = t_cyc;
      prev_dat = ps2_dat_oe;
      if (error) break;
    end
    check("tmo_error_seen", error, 1'b1);
    check("tmo_window", ((t_cyc - t_start) >= TMO - 1) && ((t_cyc - t_start) <= TMO + 1), 1'b1);
    check("tmo_lines", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
    @(negedge CLOCK_50);
    check("tmo_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of a frame.
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'hE3);
    device_receive(1'b0, 5, 1'b0, fr, low, ok);
    check("abort_reached_fe5", ok, 1'b1);
    check("abort_pre_state", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b101);
    #3;
    reset = 1'b1;
    #1;
    check("abort_async_release", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 5'b00000);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    check("abort_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
    check("abort_ready", cmd_ready, 1'b1);
    run_txn(PS2_CMD_ENABLE, 1'b0, 1'b0, "f4_after_reset");

    // A command offered while busy is dropped, not queued.
    run_txn(PS2_CMD_SET_RATE, 1'b0, 1'b1, "f3_ignore");
    repeat (200) @(negedge CLOCK_50);
    check("ignored_not_queued", {busy, ps2_clk_oe}, 2'b00);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) == 0);
      run_txn(rb, ra, 1'b0, "rand");
    end

    check("never_done_and_error", both_cnt, 0);
    check("ready_only_when_idle", rdy_bad_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
